// File: rtl/gen_pkg.sv
// -----------------------------------------------------------------------------
// gen_pkg
// Shared definitions for the rate-controlled generator blocks.
//   state_t      : generator control state (IDLE, RUN, STOPPING)
//   DEF_ACC_W    : default phase accumulator width
//   DEF_LOGSIZE  : default ROM address width
//   DEF_DIV_W    : default sample-rate prescaler width
// -----------------------------------------------------------------------------
package gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int DEF_ACC_W   = 16;
  localparam int DEF_LOGSIZE = 4;
  localparam int DEF_DIV_W   = 8;

endpackage : gen_pkg

// File: rtl/phase_addr_gen_if.sv
// -----------------------------------------------------------------------------
// phase_addr_gen_if
// Control and ROM-side bundle of the phase address generator.
//   master : controller side  - drives start/stop/tune/div, observes the rest
//   slave  : generator side   - consumes start/stop/tune/div, drives the rest
// Signals:
//   start, stop   one-cycle control pulses
//   tune [ACC_W]  phase increment per sample tick
//   div  [DIV_W]  prescaler, one tick every div+1 clocks
//   busy          generator active (RUN or STOPPING)
//   read          ROM read strobe
//   address       ROM address, valid while read=1
//   wrap          period-end marker on the read whose accumulate overflows
//   sample_valid  ROM output valid (read delayed one cycle)
//   negate        sign flag aligned with sample_valid
// -----------------------------------------------------------------------------
interface phase_addr_gen_if
  import gen_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int logsize = DEF_LOGSIZE,
  parameter int DIV_W   = DEF_DIV_W
);

  logic               start;
  logic               stop;
  logic [ACC_W-1:0]   tune;
  logic [DIV_W-1:0]   div;
  logic               busy;
  logic               read;
  logic [logsize-1:0] address;
  logic               wrap;
  logic               sample_valid;
  logic               negate;

  modport master (
    output start, stop, tune, div,
    input  busy, read, address, wrap, sample_valid, negate
  );

  modport slave (
    input  start, stop, tune, div,
    output busy, read, address, wrap, sample_valid, negate
  );

endinterface : phase_addr_gen_if

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Sample-rate prescaler: counts 0..div while enabled and flags the cycle in
// which the count reaches div. Consumers register the flag, so the visible
// strobe lands one cycle after the count equals div. div=0 ticks every clock.
// div is used live; lowering it below the current count rolls over at once.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   en    in   count enable; count is held at 0 while low
//   div   in   prescale value
//   tick  out  combinational tick flag for this cycle
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // ">=" rather than "==" so a reduced div cannot strand the count above it.
  assign tick = en && (count >= div);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule : tick_prescaler

// File: rtl/phase_addr_gen.sv
// -----------------------------------------------------------------------------
// phase_addr_gen
// DDS-style phase-accumulator address generator feeding a waveform sample ROM.
// On each prescaler tick it issues a registered ROM read whose address is the
// accumulator MSBs (pre-add value), then advances the accumulator by tune_r.
// The carry-out of that add marks the period end (wrap); tune_r reloads and a
// pending stop completes only there, so retune and stop are glitch-free.
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of phase_addr_gen_if (start/stop/tune/div in,
//             busy/read/address/wrap/sample_valid/negate out)
//
// Configuration macro QUARTER_WAVE_EN:
//   defined   - ROM holds a quarter period; address is mirrored in odd
//               quadrants and negate carries the upper-half sign.
//   undefined - full-period ROM; negate is tied 0.
// ACC_W must be at least logsize+2.
// -----------------------------------------------------------------------------
module phase_addr_gen
  import gen_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int logsize = DEF_LOGSIZE,
  parameter int DIV_W   = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  phase_addr_gen_if.slave  bus
);

  state_t             state;
  state_t             state_next;
  logic               run_en;
  logic               tick;
  logic               launch;
  logic               carry;
  logic               tick_wrap;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   tune_r;
  logic [ACC_W:0]     sum;
  logic [logsize-1:0] addr_now;

  logic               read_r;
  logic               wrap_r;
  logic               busy_r;
  logic               sample_valid_r;
  logic [logsize-1:0] address_r;

  // ---------------------------------------------------------------------------
  // Prescaler: only counts while the generator is active.
  // ---------------------------------------------------------------------------
  assign run_en = (state != IDLE);

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en),
    .div  (bus.div),
    .tick (tick)
  );

  // ---------------------------------------------------------------------------
  // Accumulator add with explicit carry; the carry is the period boundary.
  // ---------------------------------------------------------------------------
  assign sum       = {1'b0, acc} + {1'b0, tune_r};
  assign carry     = sum[ACC_W];
  assign tick_wrap = tick && carry;
  assign launch    = (state == IDLE) && bus.start && !bus.stop;

`ifdef QUARTER_WAVE_EN
  logic [1:0]         quadrant;
  logic [logsize-1:0] index;
  logic               negate_r;
  logic               negate_sv_r;

  assign quadrant = acc[ACC_W-1 -: 2];
  assign index    = acc[ACC_W-3 -: logsize];
  // Quadrants 1 and 3 walk the quarter-wave table backwards.
  assign addr_now = quadrant[0] ? ~index : index;

  always_ff @(posedge clk) begin
    if (rst) begin
      negate_r    <= 1'b0;
      negate_sv_r <= 1'b0;
    end else begin
      if (tick) begin
        negate_r <= quadrant[1];
      end
      negate_sv_r <= negate_r;
    end
  end

  assign bus.negate = negate_sv_r;
`else
  assign addr_now   = acc[ACC_W-1 -: logsize];
  assign bus.negate = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (bus.start && !bus.stop) state_next = RUN;
      RUN:      if (bus.stop)               state_next = STOPPING;
      STOPPING: if (tick_wrap)              state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered ROM-side outputs
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous - rst is only seen at a rising clk edge, so it
  // sits inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc            <= '0;
      tune_r         <= '0;
      read_r         <= 1'b0;
      wrap_r         <= 1'b0;
      busy_r         <= 1'b0;
      sample_valid_r <= 1'b0;
      address_r      <= '0;
    end else begin
      read_r         <= tick;
      wrap_r         <= tick_wrap;
      sample_valid_r <= read_r;
      // Stay busy through the final wrap read; drop the cycle after it.
      busy_r         <= (state_next != IDLE) || tick_wrap;

      if (launch) begin
        acc    <= '0;
        tune_r <= bus.tune;
      end else if (tick) begin
        address_r <= addr_now;
        acc       <= sum[ACC_W-1:0];
        // Retune only at the period boundary.
        if (carry) begin
          tune_r <= bus.tune;
        end
      end
    end
  end

  assign bus.read         = read_r;
  assign bus.wrap         = wrap_r;
  assign bus.busy         = busy_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.address      = address_r;

endmodule : phase_addr_gen

// File: tb/tb_phase_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_phase_addr_gen
// Self-checking bench for phase_addr_gen. A behavioural model predicts the
// outputs from a read schedule (first tick div+1 edges after start, then every
// div+1 edges) and an integer phase; a compare process checks every cycle.
// Directed scenarios add hand-computed literal checks. Honours QUARTER_WAVE_EN.
// -----------------------------------------------------------------------------
module tb_phase_addr_gen;

  localparam int ACC_W     = 16;
  localparam int LOGSIZE   = 4;
  localparam int DIV_W     = 8;
  localparam int PHASE_MOD = 1 << ACC_W;

`ifdef QUARTER_WAVE_EN
  localparam bit QW = 1'b1;
`else
  localparam bit QW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  phase_addr_gen_if #(.ACC_W(ACC_W), .logsize(LOGSIZE), .DIV_W(DIV_W)) bus ();

  phase_addr_gen #(.ACC_W(ACC_W), .logsize(LOGSIZE), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic int addr_of(input int ph);
    int q;
    int idx;
    if (QW) begin
      q   = ph >> (ACC_W - 2);
      idx = (ph >> (ACC_W - 2 - LOGSIZE)) % (1 << LOGSIZE);
      return (q % 2 == 1) ? ((1 << LOGSIZE) - 1 - idx) : idx;
    end
    q = 0;
    idx = 0;
    return ph >> (ACC_W - LOGSIZE);
  endfunction

  function automatic bit neg_of(input int ph);
    return QW && (ph >= PHASE_MOD / 2);
  endfunction

  bit m_active, m_stopping, was_active, ended, tk;
  int m_phase, m_step, m_first, m_period, edge_n;
  bit e_read, e_wrap, e_busy, e_sv, e_neg, e_neg_pipe;
  int e_addr;

  initial begin
    edge_n = 0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        m_active = 0; m_stopping = 0; m_phase = 0; m_step = 0;
        e_read = 0; e_wrap = 0; e_busy = 0; e_sv = 0; e_neg = 0;
        e_neg_pipe = 0; e_addr = 0;
      end else begin
        was_active = m_active;
        ended      = 0;
        e_sv       = e_read;
        e_neg      = e_neg_pipe;
        tk = was_active && (edge_n >= m_first) && ((edge_n - m_first) % m_period == 0);
        e_read = tk;
        e_wrap = 0;
        if (tk) begin
          e_addr     = addr_of(m_phase);
          e_neg_pipe = neg_of(m_phase);
          m_phase    = m_phase + m_step;
          if (m_phase >= PHASE_MOD) begin
            m_phase = m_phase - PHASE_MOD;
            e_wrap  = 1;
            m_step  = int'(bus.tune);
            if (m_stopping) begin
              m_active = 0;
              ended    = 1;
            end
          end
        end
        if (was_active && !ended && bus.stop) m_stopping = 1;
        if (!was_active && bus.start && !bus.stop) begin
          m_active   = 1;
          m_stopping = 0;
          m_phase    = 0;
          m_step     = int'(bus.tune);
          m_first    = edge_n + 1 + int'(bus.div);
          m_period   = int'(bus.div) + 1;
        end
        e_busy = m_active || ended;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("read", bus.read, e_read);
      check("busy", bus.busy, e_busy);
      check("wrap", bus.wrap, e_wrap);
      check("sample_valid", bus.sample_valid, e_sv);
      check("address", bus.address, e_addr);
      if (e_sv) check("negate", bus.negate, e_neg);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_read_addr(input int a, input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.read && bus.address == LOGSIZE'(a)) found = 1;
    end
    check(name, found, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && bus.busy; i++) @(negedge clk);
    check(name, bus.busy, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  int last_addr;
  int nreads;
  int kread;
  int ksv;
  bit wrap_found;

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.tune  = '0;
    bus.div   = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_read", bus.read, 0);
    check("rst_addr", bus.address, 0);
    check("rst_sv", bus.sample_valid, 0);
    check("rst_wrap", bus.wrap, 0);
    check("rst_negate", bus.negate, 0);
    rst = 1'b0;

    // 1: div=0, tune=0x1000 -> addresses 0..15, wrap on 15
    bus.tune = 16'h1000;
    @(negedge clk);
    pulse_start();
    check("lat1_read", bus.read, 0);
    check("lat1_busy", bus.busy, 1);
    @(negedge clk);
    check("lat2_read", bus.read, 1);
    check("first_addr", bus.address, 0);
    check("first_sv", bus.sample_valid, 0);
    repeat (15) @(negedge clk);
    check("addr15", bus.address, 15);
    check("wrap_at_15", bus.wrap, 1);
    @(negedge clk);
    check("rewrap_addr0", bus.address, 0);
    check("rewrap_sv", bus.sample_valid, 1);
    pulse_start();  // ignored while running

    // Stop at address 5 -> run to 15, then idle
    wait_read_addr(5, 40, "wait_addr5");
    pulse_stop();
    last_addr = -1;
    for (int i = 0; i < 60 && bus.busy; i++) begin
      if (bus.read) last_addr = int'(bus.address);
      @(negedge clk);
    end
    check("stop_busy_fall", bus.busy, 0);
    check("stop_last_addr", last_addr, 15);
    check("stop_final_sv", bus.sample_valid, 1);
    repeat (3) @(negedge clk);
    check("idle_no_read", bus.read, 0);

    // start and stop together in IDLE: ignored
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (2) @(negedge clk);
    check("start_stop_ignored", bus.busy, 0);

    // 2: div=3 -> one read every 4 clocks
    bus.div = 8'd3;
    pulse_start();
    repeat (4) @(negedge clk);
    nreads = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.read) nreads++;
    end
    check("div3_reads", nreads, 10);
    pulse_stop();
    wait_idle(200, "div3_idle");
    bus.div = 8'd0;
    @(negedge clk);

    // 3: mid-period retune to 0x2000 at address 3
    bus.tune = 16'h1000;
    pulse_start();
    wait_read_addr(3, 20, "wait_addr3");
    bus.tune = 16'h2000;
    wrap_found = 0;
    for (int i = 0; i < 40 && !wrap_found; i++) begin
      @(negedge clk);
      if (bus.read && bus.wrap) wrap_found = 1;
    end
    check("retune_wrap_seen", wrap_found, 1);
    @(negedge clk);
    check("retune_a0", bus.address, 0);
    @(negedge clk);
    check("retune_a2", bus.address, 2);
    @(negedge clk);
    check("retune_a4", bus.address, 4);

    // 4: reset while reading
    check("pre_rst_read", bus.read, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_read", bus.read, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_sv", bus.sample_valid, 0);
    check("mid_rst_wrap", bus.wrap, 0);
    check("mid_rst_addr", bus.address, 0);
    check("mid_rst_negate", bus.negate, 0);
    rst = 1'b0;
    bus.tune = 16'h1000;
    @(negedge clk);
    pulse_start();
    @(negedge clk);
    check("restart_read", bus.read, 1);
    check("restart_addr0", bus.address, 0);
    pulse_stop();
    wait_idle(60, "restart_idle");
    @(negedge clk);

    // 5: tune=0x0400 (quarter-wave walk when QUARTER_WAVE_EN is defined)
    bus.tune = 16'h0400;
    pulse_start();
    kread = 0;
    ksv   = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (bus.sample_valid) begin
        if (ksv == 40) check("qw_sv40_negate", bus.negate, QW ? 1 : 0);
        ksv++;
      end
      if (bus.read) begin
        if (kread == 16) check("qw_k16_addr", bus.address, QW ? 15 : 4);
        if (kread == 47) check("qw_k47_addr", bus.address, QW ? 15 : 11);
        kread++;
      end
    end
    pulse_stop();
    wait_idle(100, "qw_idle");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_phase_addr_gen

// File: doc/phase_addr_gen.md
Name: phase_addr_gen

Overview:
- Phase-accumulator address generator that sits directly upstream of the waveform sample ROM.
- Produces the ROM `read` strobe and `address` at a programmable rate and step, giving DDS-style frequency control.
- Adds a start/stop handshake with glitch-free stop and retune at period boundaries.
- Emits `sample_valid` aligned with the ROM's 1-cycle registered output.

Parameters:
- ACC_W, 16: phase accumulator width in bits; must be ≥ logsize+2.
- logsize, 4: ROM address width; the address is taken from the accumulator MSBs.
- DIV_W, 8: width of the sample-rate prescaler.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins generation from IDLE.
- stop  in  1  one-cycle pulse; requests stop at the end of the current period.
- tune  in  ACC_W  phase increment per sample tick.
- div  in  DIV_W  prescaler; one tick every div+1 clocks.
- busy  out  1  high in RUN or STOPPING.
- read  out  1  ROM read strobe, one cycle per tick.
- address  out  logsize  ROM address, valid while read=1.
- wrap  out  1  pulse with the read whose accumulate overflows (period end).
- sample_valid  out  1  read delayed one cycle; the ROM `sample` is valid this cycle.
- negate  out  1  sign flag aligned with sample_valid (see Optional Feature).

Behaviour:
- Reset: state=IDLE, acc=0, prescaler=0, tune_r=0; busy, read, wrap, sample_valid, negate all 0; address=0. Reset mid-operation drops any pending sample_valid.
- States:
  - IDLE: start=1 and stop=0 -> RUN; latch tune_r<=tune, acc<=0, prescaler<=0. start&stop together: ignored, stay IDLE.
  - RUN: stop=1 -> STOPPING. start ignored.
  - STOPPING: behaves as RUN; after the tick with wrap=1 -> IDLE. Further stop pulses are ignored.
- Prescaler counts 0..div, then rolls to 0. A tick is asserted in the cycle after the count equals div; div=0 gives a tick every clock.
  - div is sampled live.
  - Lowering div below the current count forces rollover at the next cycle.
- On a tick (RUN/STOPPING), registered outputs:
  - read=1.
  - address = acc[ACC_W-1 -: logsize], the pre-add value.
  - acc <= acc + tune_r, mod 2^ACC_W.
  - wrap = carry-out of that add.
- No tick: read=0, wrap=0, address holds its last value.
- tune_r reloads from tune only on wrap ticks, so a mid-period tune change takes effect at the next period.
- tune_r=0 in RUN: address constant, wrap never fires, stop never completes. This is the required behaviour; the controller must avoid it or reset.
- Latency: start in cycle n -> first read at cycle n+2 when div=0. sample_valid = read delayed one cycle; negate is delayed identically.
- busy falls the cycle after the final wrap read. sample_valid for that read still fires one cycle later.

Optional Feature:
- Macro QUARTER_WAVE_EN.
- Defined: the ROM holds a quarter period.
  - quadrant q = acc[ACC_W-1 -: 2].
  - index = acc[ACC_W-3 -: logsize].
  - address = index for q=0 or q=2; address = ~index for q=1 or q=3.
  - negate = q[1], registered alongside address and delayed with sample_valid.
- Undefined: full-period ROM; address as above; negate tied 0.

Decomposition:
- Shared package `gen_pkg`: state enum (IDLE, RUN, STOPPING) and default widths ACC_W/DIV_W.
- One sub-module `tick_prescaler` (clk, rst, en, div -> tick) is natural; it is reused by other rate-controlled blocks.
- Accumulator and FSM stay in the top module.

Test Plan:
- ACC_W=16, logsize=4, div=0, tune=0x1000; pulse start -> reads every cycle with address 0,1,…,15. wrap=1 on the address=15 read; then 0,1,… repeat; sample_valid trails read by exactly 1 cycle.
- div=3, tune=0x1000 -> read high 1 cycle in 4; address increments by 1 per read; busy steady high.
- Running tune=0x1000, pulse stop at address=5 -> reads continue to address=15 with wrap=1; busy low next cycle; no further reads; final sample_valid asserted.
- Mid-period change of tune to 0x2000 at address=3 -> addresses continue 4..15 by 1, then 0,2,4,… after the wrap.
- rst asserted during RUN with read=1 -> next cycle all outputs 0, including no sample_valid. start then restarts from address 0.
- QUARTER_WAVE_EN, tune=0x0400 -> addresses 0..15, then 15..0, with negate=0 for both quarters; then 0..15, 15..0 with negate=1.
